trap_sequencer: RTL
===================

Name: trap_sequencer

Overview:
- Multi-cycle controller that sequences machine-mode trap entry and MRET return after the execute stage flags an interrupt, ECALL, EBREAK or MRET.
- Performs the CSR updates for mepc, mcause and mstatus one write per cycle over the single CSR write port.
- Stalls the pipeline while it runs, then issues a one-cycle fetch redirect.
- Sits between the execute stage, the CSR file and the fetch/PC logic.

Parameters:
- VECTORED_EN, 1: when 1, mtvec[1:0]==2'b01 selects vectored mode for interrupts.
- MPP_VALUE, 2'b11: privilege value written to mstatus.MPP (machine mode only).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- interrupt_taken  input  1  execute stage took an interrupt this cycle
- ecall_exception  input  1  ECALL executed
- ebreak_exception  input  1  EBREAK executed
- mret_instruction  input  1  MRET executed
- trap_pc  input  32  PC of the instruction in execute
- interrupt_cause  input  32  cause code of the pending interrupt
- mtvec  input  32  current mtvec
- mepc  input  32  current mepc
- mstatus  input  32  current mstatus
- csr_we  output  1  CSR write strobe
- csr_waddr  output  12  CSR write address (0x341 mepc, 0x342 mcause, 0x300 mstatus)
- csr_wdata  output  32  CSR write data
- stall_pipeline  output  1  freeze IF/ID/EX while sequencing
- redirect_valid  output  1  one-cycle fetch redirect pulse
- redirect_pc  output  32  redirect target
- busy  output  1  FSM not IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs and internal latches are 0. Reset mid-sequence aborts immediately with no further CSR writes and no redirect.
- States: IDLE, SAVE_EPC, SAVE_CAUSE, UPD_STATUS, RESTORE, REDIRECT. State and latched operands are registered.
- Outputs are decoded from state and latches only (Moore); no input-to-output combinational path.
- Acceptance: only in IDLE, on a cycle where any request is 1.
  - Priority when several requests are high together: interrupt > ECALL > EBREAK > MRET. Lower-priority requests in that cycle are dropped.
  - Requests arriving while busy are ignored.
- At acceptance, latch:
  - kind
  - trap_pc
  - cause: interrupt = {1'b1, interrupt_cause[30:0]}; ECALL = 32'd11; EBREAK = 32'd3
  - mstatus
  - target:
    - trap: {mtvec[31:2], 2'b00}; if VECTORED_EN=1, kind=interrupt and mtvec[1:0]==2'b01, target = base + (cause[4:0] << 2) (32-bit wrap)
    - MRET: {mepc[31:2], 2'b00}
- Trap path (IDLE → SAVE_EPC → SAVE_CAUSE → UPD_STATUS → REDIRECT → IDLE):
  - SAVE_EPC: csr_we=1, addr 0x341, data = trap_pc & ~32'h3.
  - SAVE_CAUSE: csr_we=1, addr 0x342, data = cause.
  - UPD_STATUS: csr_we=1, addr 0x300, data = latched mstatus with bit7 (MPIE) = old bit3, bit3 (MIE) = 0, bits[12:11] = MPP_VALUE; all other bits unchanged.
- MRET path (IDLE → RESTORE → REDIRECT → IDLE):
  - RESTORE: csr_we=1, addr 0x300, data = latched mstatus with bit3 = old bit7, bit7 = 1, bits[12:11] = MPP_VALUE.
- REDIRECT: redirect_valid=1, redirect_pc = target, csr_we=0.
- csr_waddr and csr_wdata are 0 whenever csr_we=0. redirect_pc is 0 whenever redirect_valid=0.
- stall_pipeline = busy = (state != IDLE). Both deassert in the cycle after REDIRECT.
- Latency, counting the acceptance edge as edge 0:
  - trap: CSR writes on cycles 1–3, redirect on cycle 4, IDLE on cycle 5
  - MRET: write on cycle 1, redirect on cycle 2
- A new request may be accepted on the first IDLE cycle after REDIRECT (back-to-back traps are allowed).
- Latched values are immune to input changes after acceptance.

Test Plan:
- ECALL with trap_pc=0x100, mtvec=0x200, mstatus=0x8 → writes 0x341=0x100, 0x342=11, 0x300=0x1880 on consecutive cycles; redirect_pc=0x200 on cycle 4; stall high for cycles 1–4.
- Interrupt with cause=7 (timer), mtvec=0x401 (vectored) → mcause=0x80000007, redirect_pc=0x41C; with VECTORED_EN=0 → redirect_pc=0x400.
- MRET with mepc=0x104, mstatus=0x1880 → single write 0x300=0x1888; redirect_pc=0x104 on cycle 2; busy clears on cycle 3.
- interrupt_taken and mret_instruction asserted together; ECALL pulsed during SAVE_CAUSE → only the interrupt sequence runs, exactly 3 CSR writes, 1 redirect.
- rst_n driven low during SAVE_CAUSE → outputs 0 asynchronously; after release no further writes or redirect, busy=0.
- Back-to-back: EBREAK accepted on the first IDLE cycle after an MRET redirect → mcause=3, redirect to the mtvec base.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer
//   Sequences machine-mode trap entry (interrupt, ECALL, EBREAK) and MRET
//   return. It issues one CSR write per cycle (mepc, mcause, mstatus), stalls
//   the pipeline while active, and finishes with a one-cycle fetch redirect.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     interrupt_taken   execute stage took an interrupt
//     ecall_exception   ECALL executed
//     ebreak_exception  EBREAK executed
//     mret_instruction  MRET executed
//     trap_pc           PC of the instruction in execute
//     interrupt_cause   cause code of the pending interrupt
//     mtvec/mepc/mstatus current CSR values
//     csr_we/csr_waddr/csr_wdata  CSR write port (addr/data 0 when idle)
//     stall_pipeline    freeze IF/ID/EX while sequencing
//     redirect_valid/redirect_pc  one-cycle fetch redirect
//     busy              sequencer not idle
module trap_sequencer #(
   parameter bit         VECTORED_EN = 1'b1,
   parameter logic [1:0] MPP_VALUE   = 2'b11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        interrupt_taken,
   input  logic        ecall_exception,
   input  logic        ebreak_exception,
   input  logic        mret_instruction,
   input  logic [31:0] trap_pc,
   input  logic [31:0] interrupt_cause,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   input  logic [31:0] mstatus,
   output logic        csr_we,
   output logic [11:0] csr_waddr,
   output logic [31:0] csr_wdata,
   output logic        stall_pipeline,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   typedef enum logic [2:0] {
      IDLE,
      SAVE_EPC,
      SAVE_CAUSE,
      UPD_STATUS,
      RESTORE,
      REDIRECT
   } state_t;

   state_t      state;
   logic [31:0] cause_q;
   logic [31:0] status_q;
   logic [31:0] target_q;

   logic        trap_req;
   logic [31:0] acc_cause;
   logic [31:0] trap_base;
   logic [31:0] trap_target;
   logic [31:0] mret_target;
   logic        unused_bits;

   // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= MPP_VALUE.
   function automatic logic [31:0] trap_status(input logic [31:0] s);
      logic [31:0] r;
      r        = s;
      r[7]     = s[3];
      r[3]     = 1'b0;
      r[12:11] = MPP_VALUE;
      return r;
   endfunction

   // MRET: MIE <= MPIE, MPIE <= 1, MPP <= MPP_VALUE.
   function automatic logic [31:0] mret_status(input logic [31:0] s);
      logic [31:0] r;
      r        = s;
      r[3]     = s[7];
      r[7]     = 1'b1;
      r[12:11] = MPP_VALUE;
      return r;
   endfunction

   // Operands captured at acceptance; priority interrupt > ECALL > EBREAK.
   always_comb begin
      trap_req = interrupt_taken | ecall_exception | ebreak_exception;
      if (interrupt_taken)
         acc_cause = {1'b1, interrupt_cause[30:0]};
      else if (ecall_exception)
         acc_cause = 32'd11;
      else
         acc_cause = 32'd3;
      trap_base = {mtvec[31:2], 2'b00};
      if (VECTORED_EN && interrupt_taken && (mtvec[1:0] == 2'b01))
         trap_target = trap_base + {25'd0, acc_cause[4:0], 2'b00};
      else
         trap_target = trap_base;
      mret_target = {mepc[31:2], 2'b00};
   end

   assign unused_bits    = ^{interrupt_cause[31], mepc[1:0]};
   assign stall_pipeline = busy;

   // Outputs are registered together with the state they belong to, so each
   // branch loads the outputs of the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cause_q        <= '0;
         status_q       <= '0;
         target_q       <= '0;
         csr_we         <= 1'b0;
         csr_waddr      <= '0;
         csr_wdata      <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         busy           <= 1'b0;
      end else begin
         csr_we         <= 1'b0;
         csr_waddr      <= '0;
         csr_wdata      <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         busy           <= 1'b1;
         case (state)
            IDLE: begin
               if (trap_req) begin
                  state     <= SAVE_EPC;
                  cause_q   <= acc_cause;
                  status_q  <= mstatus;
                  target_q  <= trap_target;
                  csr_we    <= 1'b1;
                  csr_waddr <= ADDR_MEPC;
                  csr_wdata <= trap_pc & ~32'h3;
               end else if (mret_instruction) begin
                  state     <= RESTORE;
                  target_q  <= mret_target;
                  csr_we    <= 1'b1;
                  csr_waddr <= ADDR_MSTATUS;
                  csr_wdata <= mret_status(mstatus);
               end else begin
                  busy <= 1'b0;
               end
            end
            SAVE_EPC: begin
               state     <= SAVE_CAUSE;
               csr_we    <= 1'b1;
               csr_waddr <= ADDR_MCAUSE;
               csr_wdata <= cause_q;
            end
            SAVE_CAUSE: begin
               state     <= UPD_STATUS;
               csr_we    <= 1'b1;
               csr_waddr <= ADDR_MSTATUS;
               csr_wdata <= trap_status(status_q);
            end
            UPD_STATUS, RESTORE: begin
               state          <= REDIRECT;
               redirect_valid <= 1'b1;
               redirect_pc    <= target_q;
            end
            REDIRECT: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
